// File: rtl/proc_microsequencer.sv
// Hardwired multi-cycle control unit for the two-bus, 16-register datapath.
// Walks fetch / PC increment / decode / execute / writeback and drives every
// datapath control line from the registered state (plus ire fields where a
// step addresses registers). Holds no datapath state of its own.
module proc_microsequencer #(
  parameter bit         AUTO_START  = 1'b0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] ire,
  output logic [15:0] rd_r_a,
  output logic [15:0] rd_r_b,
  output logic [15:0] wr_r,
  output logic [15:0] wr_r_a_b,
  output logic [1:0]  rd_t_a,
  output logic [1:0]  rd_t_b,
  output logic        rd_pc,
  output logic        rd_di,
  output logic        rd_ao,
  output logic        rd_do,
  output logic        wr_t1,
  output logic        wr_t2,
  output logic        wr_t2_a_b,
  output logic        wr_pc,
  output logic        wr_pc_a_b,
  output logic        wr_ao,
  output logic        wr_ao_a_b,
  output logic        wr_di,
  output logic        wr_do,
  output logic        wr_irf,
  output logic        wr_ire,
  output logic [2:0]  alu_op,
  output logic [1:0]  k_val,
  output logic        ALU_in_2_sel,
  output logic        mem_we,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F_AO, S_F_IR, S_F_INC, S_F_PC, S_DEC,
    S_EX, S_WB, S_LA, S_LR, S_LW, S_SA, S_SW, S_J, S_ILL, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  opc;
  logic [15:0] rd_oh, rs1_oh, rs2_oh;

  assign opc    = ire[15:12];
  assign rd_oh  = 16'h0001 << ire[11:8];
  assign rs1_oh = 16'h0001 << ire[7:4];
  assign rs2_oh = 16'h0001 << ire[3:0];

  // State register; reset lands in IDLE, which decodes to all-zero outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: linear fetch, opcode branch in DEC, every instruction returns to F_AO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start || AUTO_START) state_d = S_F_AO;
      S_F_AO:  state_d = S_F_IR;
      S_F_IR:  state_d = S_F_INC;
      S_F_INC: state_d = S_F_PC;
      S_F_PC:  state_d = S_DEC;
      S_DEC: begin
        // Halt check first so HALT_OPCODE may shadow any other opcode.
        if (opc == HALT_OPCODE)  state_d = S_HALT;
        else if (opc <= 4'h9)    state_d = S_EX;
        else if (opc == 4'hA)    state_d = S_LA;
        else if (opc == 4'hB)    state_d = S_SA;
        else if (opc == 4'hC)    state_d = S_J;
        else                     state_d = S_ILL;
      end
      S_EX:    state_d = S_WB;
      S_LA:    state_d = S_LR;
      S_LR:    state_d = S_LW;
      S_SA:    state_d = S_SW;
      S_WB, S_LW, S_SW, S_J, S_ILL: state_d = S_F_AO;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    rd_r_a = '0; rd_r_b = '0; wr_r = '0; wr_r_a_b = '0;
    rd_t_a = '0; rd_t_b = '0;
    rd_pc = 1'b0; rd_di = 1'b0; rd_ao = 1'b0; rd_do = 1'b0;
    wr_t1 = 1'b0; wr_t2 = 1'b0; wr_t2_a_b = 1'b0;
    wr_pc = 1'b0; wr_pc_a_b = 1'b0; wr_ao = 1'b0; wr_ao_a_b = 1'b0;
    wr_di = 1'b0; wr_do = 1'b0; wr_irf = 1'b0; wr_ire = 1'b0;
    alu_op = 3'b000; k_val = 2'b00; ALU_in_2_sel = 1'b0; mem_we = 1'b0;
    busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    halted  = (state_q == S_HALT);
    illegal = (state_q == S_ILL);
    case (state_q)
      S_F_AO: begin rd_pc = 1'b1; wr_ao = 1'b1; wr_ao_a_b = 1'b1; end
      S_F_IR: begin rd_ao = 1'b1; wr_irf = 1'b1; end
      S_F_INC: begin
        rd_pc = 1'b1; ALU_in_2_sel = 1'b1; k_val = 2'b01; wr_t1 = 1'b1;
      end
      S_F_PC: begin
        rd_t_a = 2'b01; wr_pc = 1'b1; wr_pc_a_b = 1'b1; wr_ire = 1'b1;
      end
      S_EX: begin
        rd_r_a = rs1_oh;
        wr_t1  = 1'b1;
        if (!opc[3]) begin
          rd_r_b = rs2_oh;
          alu_op = opc[2:0];
        end else begin
          // INC (8) adds +1, DEC (9) adds FFFF
          ALU_in_2_sel = 1'b1;
          k_val        = opc[0] ? 2'b10 : 2'b01;
        end
      end
      S_WB: begin rd_t_a = 2'b01; wr_r = rd_oh; wr_r_a_b = rd_oh; end
      S_LA: begin rd_r_a = rs1_oh; wr_ao = 1'b1; wr_ao_a_b = 1'b1; end
      S_LR: begin rd_ao = 1'b1; wr_di = 1'b1; end
      S_LW: begin rd_di = 1'b1; wr_r = rd_oh; end
      S_SA: begin
        rd_r_a = rs1_oh; wr_ao = 1'b1; wr_ao_a_b = 1'b1;
        rd_r_b = rs2_oh; wr_do = 1'b1;
      end
      S_SW: begin rd_do = 1'b1; mem_we = 1'b1; end
      S_J:  begin rd_r_a = rs1_oh; wr_pc = 1'b1; wr_pc_a_b = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_microsequencer.sv
// Bench for proc_microsequencer: directed test-plan instructions plus a
// random-opcode regression, every cycle compared against a per-instruction
// list of expected control words built from the instruction semantics.
module tb_proc_microsequencer;

  logic        clock, reset_n, start;
  logic [15:0] ire;
  logic [15:0] rd_r_a, rd_r_b, wr_r, wr_r_a_b;
  logic [1:0]  rd_t_a, rd_t_b;
  logic rd_pc, rd_di, rd_ao, rd_do, wr_t1, wr_t2, wr_t2_a_b, wr_pc, wr_pc_a_b;
  logic wr_ao, wr_ao_a_b, wr_di, wr_do, wr_irf, wr_ire;
  logic [2:0]  alu_op;
  logic [1:0]  k_val;
  logic ALU_in_2_sel, mem_we, busy, halted, illegal;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] rd_r_a, rd_r_b, wr_r, wr_r_a_b;
    logic [1:0]  rd_t_a, rd_t_b;
    logic rd_pc, rd_di, rd_ao, rd_do, wr_t1, wr_t2, wr_t2_a_b, wr_pc, wr_pc_a_b;
    logic wr_ao, wr_ao_a_b, wr_di, wr_do, wr_irf, wr_ire;
    logic [2:0]  alu_op;
    logic [1:0]  k_val;
    logic alu_in_2_sel, mem_we, busy, halted, illegal;
  } ctl_t;

  ctl_t exp_q[$];

  proc_microsequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ire(ire),
    .rd_r_a(rd_r_a), .rd_r_b(rd_r_b), .wr_r(wr_r), .wr_r_a_b(wr_r_a_b),
    .rd_t_a(rd_t_a), .rd_t_b(rd_t_b), .rd_pc(rd_pc), .rd_di(rd_di),
    .rd_ao(rd_ao), .rd_do(rd_do), .wr_t1(wr_t1), .wr_t2(wr_t2),
    .wr_t2_a_b(wr_t2_a_b), .wr_pc(wr_pc), .wr_pc_a_b(wr_pc_a_b),
    .wr_ao(wr_ao), .wr_ao_a_b(wr_ao_a_b), .wr_di(wr_di), .wr_do(wr_do),
    .wr_irf(wr_irf), .wr_ire(wr_ire), .alu_op(alu_op), .k_val(k_val),
    .ALU_in_2_sel(ALU_in_2_sel), .mem_we(mem_we), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t o;
    o = '0;
    o.rd_r_a = rd_r_a; o.rd_r_b = rd_r_b; o.wr_r = wr_r; o.wr_r_a_b = wr_r_a_b;
    o.rd_t_a = rd_t_a; o.rd_t_b = rd_t_b;
    o.rd_pc = rd_pc; o.rd_di = rd_di; o.rd_ao = rd_ao; o.rd_do = rd_do;
    o.wr_t1 = wr_t1; o.wr_t2 = wr_t2; o.wr_t2_a_b = wr_t2_a_b;
    o.wr_pc = wr_pc; o.wr_pc_a_b = wr_pc_a_b; o.wr_ao = wr_ao; o.wr_ao_a_b = wr_ao_a_b;
    o.wr_di = wr_di; o.wr_do = wr_do; o.wr_irf = wr_irf; o.wr_ire = wr_ire;
    o.alu_op = alu_op; o.k_val = k_val; o.alu_in_2_sel = ALU_in_2_sel;
    o.mem_we = mem_we; o.busy = busy; o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  // Bus-exclusivity invariants, every cycle of the run.
  always @(negedge clock) begin
    chk("bus_a_excl", 128'($countones({rd_r_a, rd_t_a, rd_pc}) <= 1), 128'(1));
    chk("bus_b_excl", 128'($countones({rd_r_b, rd_t_b, rd_pc, rd_di}) <= 1), 128'(1));
    chk("ao_vs_we",   128'(rd_ao & mem_we), 128'(0));
  end

  // Reference: expected control word per cycle, from fetch through the
  // instruction's last step (HALT stops after DEC; caller checks HALT).
  task automatic build(input logic [15:0] ins);
    ctl_t c;
    logic [3:0] opc;
    logic [15:0] rd1, rs1, rs2;
    opc = ins[15:12];
    rd1 = 16'(1) << ins[11:8];
    rs1 = 16'(1) << ins[7:4];
    rs2 = 16'(1) << ins[3:0];
    exp_q.delete();
    c = '0; c.busy = 1; c.rd_pc = 1; c.wr_ao = 1; c.wr_ao_a_b = 1; exp_q.push_back(c);
    c = '0; c.busy = 1; c.rd_ao = 1; c.wr_irf = 1; exp_q.push_back(c);
    c = '0; c.busy = 1; c.rd_pc = 1; c.alu_in_2_sel = 1; c.k_val = 2'b01; c.wr_t1 = 1;
    exp_q.push_back(c);
    c = '0; c.busy = 1; c.rd_t_a = 2'b01; c.wr_pc = 1; c.wr_pc_a_b = 1; c.wr_ire = 1;
    exp_q.push_back(c);
    c = '0; c.busy = 1; exp_q.push_back(c);
    if (opc == 4'hF) return;
    if (opc < 4'h8) begin
      c = '0; c.busy = 1; c.rd_r_a = rs1; c.rd_r_b = rs2; c.alu_op = opc[2:0]; c.wr_t1 = 1;
      exp_q.push_back(c);
    end else if (opc == 4'h8 || opc == 4'h9) begin
      c = '0; c.busy = 1; c.rd_r_a = rs1; c.alu_in_2_sel = 1; c.wr_t1 = 1;
      c.k_val = (opc == 4'h8) ? 2'b01 : 2'b10;
      exp_q.push_back(c);
    end
    if (opc <= 4'h9) begin
      c = '0; c.busy = 1; c.rd_t_a = 2'b01; c.wr_r = rd1; c.wr_r_a_b = rd1; exp_q.push_back(c);
    end else if (opc == 4'hA) begin
      c = '0; c.busy = 1; c.rd_r_a = rs1; c.wr_ao = 1; c.wr_ao_a_b = 1; exp_q.push_back(c);
      c = '0; c.busy = 1; c.rd_ao = 1; c.wr_di = 1; exp_q.push_back(c);
      c = '0; c.busy = 1; c.rd_di = 1; c.wr_r = rd1; exp_q.push_back(c);
    end else if (opc == 4'hB) begin
      c = '0; c.busy = 1; c.rd_r_a = rs1; c.wr_ao = 1; c.wr_ao_a_b = 1;
      c.rd_r_b = rs2; c.wr_do = 1; exp_q.push_back(c);
      c = '0; c.busy = 1; c.rd_do = 1; c.mem_we = 1; exp_q.push_back(c);
    end else if (opc == 4'hC) begin
      c = '0; c.busy = 1; c.rd_r_a = rs1; c.wr_pc = 1; c.wr_pc_a_b = 1; exp_q.push_back(c);
    end else begin
      c = '0; c.busy = 1; c.illegal = 1; exp_q.push_back(c);
    end
  endtask

  // One cycle: compare at the falling edge, then advance past the rising edge.
  task automatic do_step(input ctl_t e, input string tag);
    ctl_t o;
    @(negedge clock);
    o = sample();
    chk(tag, 128'(o), 128'(e));
    @(posedge clock);
    #1;
  endtask

  // Run one instruction starting in F_AO; abort_at >= 0 asserts reset in that step.
  task automatic run_instr(input logic [15:0] ins, input int abort_at);
    build(ins);
    ire = ins;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) reset_n = 1'b0;
      do_step(exp_q[i], $sformatf("ins_%h_step%0d", ins, i + 1));
      if (i == abort_at) break;
      start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    ctl_t z, h;
    z = '0;
    h = '0; h.halted = 1;
    reset_n = 1'b0; start = 1'b0; ire = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    do_step(z, "reset_state");
    reset_n = 1'b1; start = 1'b0;
    do_step(z, "idle_wait");
    do_step(z, "idle_wait2");
    start = 1'b1;
    do_step(z, "idle_go");

    run_instr(16'h0312, -1);
    run_instr(16'h9550, -1);
    run_instr(16'hA740, -1);
    run_instr(16'hB012, -1);
    run_instr(16'hE000, -1);
    run_instr(16'h8330, -1);
    run_instr(16'hC050, -1);
    run_instr(16'h7555, -1);
    run_instr(16'hD123, -1);

    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [11:0] fld;
      op  = 4'($urandom_range(0, 14));
      fld = 12'($urandom);
      run_instr({op, fld}, -1);
    end

    // Reset during LR of a LOAD (step 7: 5 fetch/decode + LA + LR).
    run_instr(16'hA740, 6);
    do_step(z, "reset_mid_load");
    reset_n = 1'b1; start = 1'b0;
    do_step(z, "idle_after_reset");
    start = 1'b1;
    do_step(z, "idle_go2");
    run_instr(16'h0312, -1);

    // HALT is sticky and ignores start.
    run_instr(16'hF000, -1);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      do_step(h, $sformatf("halt_cycle%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/proc_microsequencer.md
Name: proc_microsequencer

Overview:
- Hardwired multi-cycle control unit for the two-bus (A/B) 16-register processor datapath.
- Sequences instruction fetch, PC increment, decode, execute and writeback by driving every datapath read, write, mux, ALU and constant-select control line once per clock.
- Instructions come from the datapath's execute instruction register (ire).
- The block does not hold datapath state. It only generates control signals.

Parameters:
- AUTO_START, 0, 1 = leave IDLE on the first cycle after reset without waiting for start.
- HALT_OPCODE, 4'hF, opcode that enters the sticky HALT state.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  level; leaves IDLE when high.
- ire  in  16  current instruction: [15:12] opc, [11:8] rd, [7:4] rs1, [3:0] rs2.
- rd_r_a, rd_r_b, wr_r, wr_r_a_b  out  16 each  one-hot register-file read/write controls; wr_r_a_b bit = 1 selects bus A.
- rd_t_a, rd_t_b  out  2 each  temp-register bus drives.
- rd_pc, rd_di, rd_ao, rd_do  out  1 each  bus drives.
- wr_t1, wr_t2, wr_t2_a_b, wr_pc, wr_pc_a_b, wr_ao, wr_ao_a_b, wr_di, wr_do, wr_irf, wr_ire  out  1 each  write enables and source selects.
- alu_op  out  3  ALU function.
- k_val  out  2  constant select: 00 = 0, 01 = 1, 1x = FFFF.
- ALU_in_2_sel  out  1  1 = ALU B input is k.
- mem_we  out  1  memory write strobe; address = ao, data = edb.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Control outputs are a Moore decode of the registered state, plus ire fields where a step reads ire.
- Any control not listed for a state is 0.
- Reset (reset_n = 0 at an edge): state = IDLE and every output = 0, including mid-instruction. Datapath contents are not touched.
- IDLE: waits for start = 1 (or AUTO_START = 1), then goes to F_AO.
- F_AO: rd_pc, wr_ao, wr_ao_a_b.
- F_IR: rd_ao, wr_irf.
- F_INC: rd_pc, ALU_in_2_sel, k_val = 01, alu_op = 000, wr_t1.
- F_PC: rd_t_a = 01, wr_pc, wr_pc_a_b, wr_ire.
- DEC: no controls; branches on ire[15:12].
- Opc 0–7 (reg-reg ALU):
  - EX: rd_r_a[rs1], rd_r_b[rs2], alu_op = opc[2:0], wr_t1.
  - WB: rd_t_a = 01, wr_r[rd], wr_r_a_b[rd] = 1.
  - Then F_AO.
- Opc 8 INC / 9 DEC:
  - EX: rd_r_a[rs1], ALU_in_2_sel, alu_op = 000, k_val = 01 (INC) or 10 (DEC), wr_t1.
  - Then WB as for opc 0–7.
- Opc A LOAD:
  - LA: rd_r_a[rs1], wr_ao, wr_ao_a_b.
  - LR: rd_ao, wr_di.
  - LW: rd_di, wr_r[rd], wr_r_a_b[rd] = 0.
  - Then F_AO.
- Opc B STORE:
  - SA: rd_r_a[rs1], wr_ao, wr_ao_a_b, rd_r_b[rs2], wr_do.
  - SW: rd_do, mem_we.
  - Then F_AO.
- Opc C JMP:
  - J: rd_r_a[rs1], wr_pc, wr_pc_a_b.
  - Then F_AO.
- Opc = HALT_OPCODE: enters HALT. HALT is sticky; only reset leaves it. start is ignored in HALT.
- Other opcodes (D, E): illegal = 1 for one cycle in state ILL (no other controls), then F_AO.
- Instruction latency from F_AO: ALU/INC/DEC 7 cycles, LOAD 8, STORE 7, JMP 6.
- Register aliasing: rd == rs1 and rs1 == rs2 are legal. Reads and writes always fall in different states.
- Bus exclusivity invariant, every cycle:
  - At most one of {rd_r_a bits, rd_t_a bits, rd_pc} is set.
  - At most one of {rd_r_b bits, rd_t_b bits, rd_pc, rd_di} is set.
  - rd_ao and mem_we are never both set.
- wr_t2 and rd_t_b are reserved and held at 0.
- start deasserting mid-instruction has no effect.

Test Plan:
- Reset hold, then ire = 16'h0312, start = 1 (ADD r3 = r1 + r2):
  - Cycles 1–4 show the fetch pattern above.
  - Cycle 6: rd_r_a = 16'h0002, rd_r_b = 16'h0004, alu_op = 000.
  - Cycle 7: wr_r = 16'h0008, wr_r_a_b = 16'h0008.
  - Cycle 8 is F_AO again.
- ire = 16'h9550 (DEC r5): EX has k_val = 10, ALU_in_2_sel = 1, rd_r_a = 16'h0020; WB has wr_r = 16'h0020.
- ire = 16'hA740 (LOAD r7 ← mem[r4]): LA rd_r_a = 16'h0010; LR rd_ao = 1, wr_di = 1; LW rd_di = 1, wr_r = 16'h0080, wr_r_a_b = 0.
- ire = 16'hB012 (STORE mem[r1] ← r2): SA has wr_ao and wr_do together; SW has mem_we = 1, rd_do = 1, rd_ao = 0.
- ire = 16'hE000: illegal pulses for exactly 1 cycle, then fetch resumes. ire = 16'hF000: halted = 1, busy = 0 and all controls 0 for 20 cycles with start toggling.
- reset_n = 0 asserted in the LR cycle of a LOAD: all outputs 0 on the next edge, state IDLE. A bus-exclusivity assertion checker runs for the full random-opcode regression.
